dmem_sram_ctrl: RTL and testbench
=================================

// Module: dmem_sram_ctrl
// PURPOSE
//  Responder side of the MEM-stage data-memory interface (dm_addr/dm_rw/dm_wbe_n/dm_wdata/dm_rdata).
//  Converts one MEM-stage load/store request into a timed cycle on an external async 32-bit SRAM,
//  stalls the MEM stage via dm_busy_o, and returns the full read word on dm_rdata_o.
//  Sits between the MEM stage and the board SRAM pins; top level builds the tristate from dq_o/dq_oe.
// PARAMETERS
//  ADDR_W    20  SRAM word-address width; sram_addr_o = dm_addr_i[ADDR_W+1:2]
//  RD_WAIT   1   extra read cycles; read strobe held RD_WAIT+1 cycles (min 0)
//  WR_PULSE  1   cycles sram_we_n_o held low (min 1)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst_n        in   1       synchronous reset, active low
//  dm_req_i     in   1       MEM stage valid load/store this cycle (held stable while dm_busy_o=1)
//  dm_rw_i      in   1       1 = read, 0 = write
//  dm_addr_i    in   32      byte address; [1:0] ignored
//  dm_wbe_n_i   in   4       active-low byte-lane write enables (1110 byte, 1100 half, 0000 word)
//  dm_wdata_i   in   32      write data, lanes passed through unshifted
//  dm_rdata_o   out  32      last completed read word, held until next read completes
//  dm_busy_o    out  1       stall MEM stage (combinational)
//  dm_done_o    out  1       1-cycle pulse: access complete, dm_rdata_o valid for reads
//  sram_addr_o  out  ADDR_W  SRAM word address
//  sram_be_n_o  out  4       SRAM byte enables, active low
//  sram_ce_n_o  out  1       chip enable, active low
//  sram_oe_n_o  out  1       output enable, active low
//  sram_we_n_o  out  1       write enable, active low
//  sram_dq_i    in   32      SRAM data in
//  sram_dq_o    out  32      SRAM data out
//  sram_dq_oe_o out  1       1 = controller drives data bus
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE, ce_n=oe_n=we_n=1, be_n=4'hF, dq_oe=0, addr=0, dq_o=0, rdata=0, done=0.
//  - All sram_* and dm_rdata_o/dm_done_o registered; listed pin values hold for every cycle spent in a state.
//  - dm_busy_o = rst_n & dm_req_i & (state != DONE).
//  - States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
//  - IDLE: on dm_req_i latch addr/rw/be_n/wdata. rw=1 -> RD; rw=0 & be_n!=F -> WR_SETUP; rw=0 & be_n==F -> DONE (no SRAM cycle).
//  - RD: ce_n=0, oe_n=0, be_n=0000, dq_oe=0; counter RD_WAIT+1 cycles; last RD cycle samples sram_dq_i into dm_rdata_o -> DONE.
//  - WR_SETUP (1 cyc): ce_n=0, we_n=1, oe_n=1, be_n=latched, dq_oe=1, dq_o=latched wdata.
//  - WR_PULSE (WR_PULSE cyc): as setup with we_n=0.  WR_HOLD (1 cyc): we_n=1, dq_oe=1, ce_n=0 -> DONE.
//  - DONE (1 cyc): ce_n=oe_n=we_n=1, be_n=F, dq_oe=0, done=1, busy=0; MEM stage advances; -> IDLE.
//  - Latency from request cycle to DONE: read 1+RD_WAIT+1; write 3+WR_PULSE; null write (be_n=F) 1.
//  - New request earliest in IDLE cycle after DONE (one idle turnaround cycle; no bus contention).
//  - dm_req_i dropping mid-access (flush): access still completes, done still pulses; inputs ignored outside IDLE.
//  - we_n never low while oe_n low; dq_oe never 1 while oe_n low.
//  - Reset mid-access: next edge forces reset values, no done pulse, partial write permitted.
//  - Address bits above ADDR_W+1 ignored (wrap); no misalignment check (MEM stage guarantees).
// TESTING
//  1 Reset 2 cycles with dm_req_i=1 -> all pins at reset values, busy=0 during reset, rdata=0.
//  2 Write addr 0x10, data 0xDEADBEEF, be_n 0000 (defaults) -> sram_addr=0x4, we_n low cycle 2 only, dq_oe cycles 1-3, done at cycle 4, busy cycles 0-3.
//  3 Read addr 0x10 from SRAM model -> oe_n/ce_n low cycles 1-2, done cycle 3, dm_rdata_o=0xDEADBEEF, held after.
//  4 Byte write be_n 1110 data 0x000000A5 to 0x10, then read -> sram_be_n=1110 during write, read returns 0xDEADBEA5.
//  5 Write with be_n 1111 -> ce_n stays 1, done at cycle 1; then RD_WAIT=3 read -> done at cycle 5.
//  6 Back-to-back req held high: next access starts IDLE cycle after DONE; rst_n=0 during WR_PULSE -> we_n=1, dq_oe=0 next edge, no done.

Source files
------------

// File: rtl/dmem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_sram_ctrl
//   Responder for the MEM-stage data-memory port. Each accepted load/store is
//   turned into one timed cycle on an external asynchronous 32-bit SRAM. The
//   MEM stage is stalled through dm_busy_o until the access reaches DONE, at
//   which point dm_done_o pulses and (for loads) dm_rdata_o holds the word.
//
// Ports
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   dm_req_i          MEM stage has a valid load/store this cycle
//   dm_rw_i           1 = read, 0 = write
//   dm_addr_i         byte address; [1:0] and bits above ADDR_W+1 ignored
//   dm_wbe_n_i        active-low byte-lane write enables
//   dm_wdata_i        write data, lanes unshifted
//   dm_rdata_o        last completed read word
//   dm_busy_o         combinational stall to the MEM stage
//   dm_done_o         one-cycle completion pulse
//   sram_addr_o       SRAM word address
//   sram_be_n_o       SRAM byte enables (active low)
//   sram_ce_n_o       SRAM chip enable (active low)
//   sram_oe_n_o       SRAM output enable (active low)
//   sram_we_n_o       SRAM write enable (active low)
//   sram_dq_i         SRAM data bus, input side
//   sram_dq_o         SRAM data bus, output side
//   sram_dq_oe_o      1 = controller drives the data bus
// ---------------------------------------------------------------------------
module dmem_sram_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int RD_WAIT  = 1,
  parameter int WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dm_req_i,
  input  logic              dm_rw_i,
  input  logic [31:0]       dm_addr_i,
  input  logic [3:0]        dm_wbe_n_i,
  input  logic [31:0]       dm_wdata_i,
  output logic [31:0]       dm_rdata_o,
  output logic              dm_busy_o,
  output logic              dm_done_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [3:0]        sram_be_n_o,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  input  logic [31:0]       sram_dq_i,
  output logic [31:0]       sram_dq_o,
  output logic              sram_dq_oe_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE
  } state_t;

  // Last counter value of the read strobe and of the write pulse.
  localparam logic [7:0] RD_LAST = 8'(RD_WAIT);
  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);

  state_t              r_state;
  state_t              w_nextState;
  logic [7:0]          r_cnt;
  logic [3:0]          r_beN;
  logic [31:0]         r_rdata;
  logic                r_done;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_sramBeN;
  logic                r_ceN;
  logic                r_oeN;
  logic                r_weN;
  logic [31:0]         r_dqOut;
  logic                r_dqOe;

  logic                w_accept;
  logic [3:0]          w_beSel;
  logic                w_ceN;
  logic                w_oeN;
  logic                w_weN;
  logic [3:0]          w_beN;
  logic                w_dqOe;
  logic                w_done;
  logic                w_unusedAddrBits;

  assign w_unusedAddrBits = ^{dm_addr_i[31:ADDR_W+2], dm_addr_i[1:0]};

  // Requests are only looked at while idle; afterwards the latched copy rules.
  assign w_accept = (r_state == S_IDLE) && dm_req_i;
  assign w_beSel  = w_accept ? dm_wbe_n_i : r_beN;

  assign dm_busy_o = rst_n & dm_req_i & (r_state != S_DONE);

  // Next-state decode. A write with no lanes enabled skips the SRAM entirely.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (dm_req_i) begin
          if (dm_rw_i)                   w_nextState = S_RD;
          else if (dm_wbe_n_i != 4'hF)   w_nextState = S_WR_SETUP;
          else                           w_nextState = S_DONE;
        end
      end
      S_RD:       if (r_cnt == RD_LAST) w_nextState = S_DONE;
      S_WR_SETUP: w_nextState = S_WR_PULSE;
      S_WR_PULSE: if (r_cnt == WR_LAST) w_nextState = S_WR_HOLD;
      S_WR_HOLD:  w_nextState = S_DONE;
      S_DONE:     w_nextState = S_IDLE;
      default:    w_nextState = S_IDLE;
    endcase
  end

  // Pin values are decoded from the state being entered so the registered
  // pins are already correct in the first cycle spent in that state.
  always_comb begin
    w_ceN  = 1'b1;
    w_oeN  = 1'b1;
    w_weN  = 1'b1;
    w_beN  = 4'hF;
    w_dqOe = 1'b0;
    w_done = 1'b0;
    case (w_nextState)
      S_RD: begin
        w_ceN = 1'b0;
        w_oeN = 1'b0;
        w_beN = 4'h0;
      end
      S_WR_SETUP, S_WR_HOLD: begin
        w_ceN  = 1'b0;
        w_beN  = w_beSel;
        w_dqOe = 1'b1;
      end
      S_WR_PULSE: begin
        w_ceN  = 1'b0;
        w_weN  = 1'b0;
        w_beN  = w_beSel;
        w_dqOe = 1'b1;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // State, cycle counter, request latch and registered pins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_beN     <= 4'hF;
      r_rdata   <= 32'd0;
      r_done    <= 1'b0;
      r_addr    <= '0;
      r_sramBeN <= 4'hF;
      r_ceN     <= 1'b1;
      r_oeN     <= 1'b1;
      r_weN     <= 1'b1;
      r_dqOut   <= 32'd0;
      r_dqOe    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_cnt     <= (w_nextState != r_state) ? 8'd0 : r_cnt + 8'd1;
      if (w_accept) begin
        r_beN   <= dm_wbe_n_i;
        r_addr  <= dm_addr_i[ADDR_W+1:2];
        r_dqOut <= dm_wdata_i;
      end
      // The final strobe cycle is the one whose data is captured.
      if (r_state == S_RD && w_nextState == S_DONE) r_rdata <= sram_dq_i;
      r_done    <= w_done;
      r_sramBeN <= w_beN;
      r_ceN     <= w_ceN;
      r_oeN     <= w_oeN;
      r_weN     <= w_weN;
      r_dqOe    <= w_dqOe;
    end
  end

  assign dm_rdata_o   = r_rdata;
  assign dm_done_o    = r_done;
  assign sram_addr_o  = r_addr;
  assign sram_be_n_o  = r_sramBeN;
  assign sram_ce_n_o  = r_ceN;
  assign sram_oe_n_o  = r_oeN;
  assign sram_we_n_o  = r_weN;
  assign sram_dq_o    = r_dqOut;
  assign sram_dq_oe_o = r_dqOe;

endmodule

// File: tb/tb_dmem_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dmem_sram_ctrl
//   Drives MEM-stage loads/stores into dmem_sram_ctrl (default timing) and a
//   second copy built with RD_WAIT=3, models the async SRAM on the pins and
//   keeps a word-level reference memory updated from the requests issued.
// ---------------------------------------------------------------------------
module tb_dmem_sram_ctrl;

  localparam int RDW = 1;
  localparam int WRP = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req;
  logic        rw;
  logic [31:0] addr;
  logic [3:0]  wbe;
  logic [31:0] wdata;

  logic [31:0] rdata, sDqI, sDqO;
  logic        busy, done, sCe, sOe, sWe, sDqOe;
  logic [19:0] sAddr;
  logic [3:0]  sBe;

  logic [31:0] rdata3, sDqI3, sDqO3;
  logic        busy3, done3, sCe3, sOe3, sWe3, sDqOe3;
  logic [19:0] sAddr3;
  logic [3:0]  sBe3;

  int testCount = 0;
  int failCount = 0;

  logic [31:0] sramMem [0:15];
  logic [31:0] refMem  [0:15];
  bit          memInit = 1'b0;

  logic        trCe [0:39];
  logic        trOe [0:39];
  logic        trWe [0:39];
  logic        trDqOe [0:39];
  logic        trBusy [0:39];
  logic [3:0]  trBe [0:39];
  logic [19:0] trAddr [0:39];
  logic [31:0] trDq [0:39];

  dmem_sram_ctrl #(.ADDR_W(20), .RD_WAIT(RDW), .WR_PULSE(WRP)) dut (
    .clk(clk), .rst_n(rst_n), .dm_req_i(req), .dm_rw_i(rw), .dm_addr_i(addr),
    .dm_wbe_n_i(wbe), .dm_wdata_i(wdata), .dm_rdata_o(rdata), .dm_busy_o(busy),
    .dm_done_o(done), .sram_addr_o(sAddr), .sram_be_n_o(sBe), .sram_ce_n_o(sCe),
    .sram_oe_n_o(sOe), .sram_we_n_o(sWe), .sram_dq_i(sDqI), .sram_dq_o(sDqO),
    .sram_dq_oe_o(sDqOe));

  dmem_sram_ctrl #(.ADDR_W(20), .RD_WAIT(3), .WR_PULSE(WRP)) dut3 (
    .clk(clk), .rst_n(rst_n), .dm_req_i(req), .dm_rw_i(rw), .dm_addr_i(addr),
    .dm_wbe_n_i(wbe), .dm_wdata_i(wdata), .dm_rdata_o(rdata3), .dm_busy_o(busy3),
    .dm_done_o(done3), .sram_addr_o(sAddr3), .sram_be_n_o(sBe3), .sram_ce_n_o(sCe3),
    .sram_oe_n_o(sOe3), .sram_we_n_o(sWe3), .sram_dq_i(sDqI3), .sram_dq_o(sDqO3),
    .sram_dq_oe_o(sDqOe3));

  // Async SRAM read path: data only appears while chip and output enable are low.
  assign sDqI  = (sCe === 1'b0 && sOe === 1'b0 && sAddr[19:4] == 16'd0)
                 ? sramMem[sAddr[3:0]] : 32'hxxxxxxxx;
  assign sDqI3 = (sCe3 === 1'b0 && sOe3 === 1'b0 && sAddr3[19:4] == 16'd0)
                 ? sramMem[sAddr3[3:0]] : 32'hxxxxxxxx;

  function automatic logic [31:0] initVal(input int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] beN);
    logic [31:0] res;
    res = old;
    for (int l = 0; l < 4; l++) if (!beN[l]) res[8*l +: 8] = d[8*l +: 8];
    return res;
  endfunction

  // SRAM array write on the pins, plus bus-protocol watch on the main instance.
  always @(negedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 16; i++) sramMem[i] = initVal(i);
      memInit = 1'b1;
    end
    if (sCe === 1'b0 && sWe === 1'b0 && sAddr[19:4] == 16'd0)
      for (int l = 0; l < 4; l++)
        if (sBe[l] === 1'b0) sramMem[sAddr[3:0]][8*l +: 8] = sDqO[8*l +: 8];
    if (sOe === 1'b0) begin
      testCount++;
      if (sWe !== 1'b1 || sDqOe !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL bus_protocol: oe_n low with we_n=%b dq_oe=%b (need 1/0)", sWe, sDqOe);
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic pulseReset();
    rst_n = 1'b0;
    req   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Issues one request (called 1 time unit after a rising edge with the DUT
  // idle) and records the main instance's pins at every falling edge until
  // dm_done_o is seen. dc = cycle index of done, -1 if it never came.
  task automatic runAccess(input logic r, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d, input bit drop, input bit keep,
                           output int dc);
    dc = -1;
    rw = r; addr = a; wbe = b; wdata = d; req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      trCe[k] = sCe; trOe[k] = sOe; trWe[k] = sWe; trDqOe[k] = sDqOe;
      trBusy[k] = busy; trBe[k] = sBe; trAddr[k] = sAddr; trDq[k] = sDqO;
      if (done === 1'b1) begin
        dc = k;
        break;
      end
      @(posedge clk); #1;
      if (drop) req = 1'b0;
    end
    @(posedge clk); #1;
    if (!keep) req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; rw = 1'b0; wbe = 4'h0;
    addr = 32'h10; wdata = 32'h1234_5678;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      testCount++;
      if (busy !== 1'b0 || busy3 !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset_busy: busy=%b busy3=%b, need 0", busy, busy3);
      end
      @(posedge clk);
    end
    @(negedge clk);
    testCount++;
    if ({sCe, sOe, sWe, sBe, sDqOe, done} !== 9'b1_1_1_1111_0_0 ||
        sAddr !== 20'd0 || sDqO !== 32'd0 || rdata !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL reset_pins: ce=%b oe=%b we=%b be=%h dqoe=%b done=%b addr=%h dq=%h rdata=%h, need 1 1 1 f 0 0 0 0 0",
               sCe, sOe, sWe, sBe, sDqOe, done, sAddr, sDqO, rdata);
    end
    testCount++;
    if ({sCe3, sOe3, sWe3, sBe3, sDqOe3, done3} !== 9'b1_1_1_1111_0_0 ||
        sAddr3 !== 20'd0 || sDqO3 !== 32'd0 || rdata3 !== 32'd0) begin
      failCount++;
      $display("[TB] FAIL reset_pins3: ce=%b oe=%b we=%b be=%h dqoe=%b done=%b addr=%h dq=%h rdata=%h, need reset values",
               sCe3, sOe3, sWe3, sBe3, sDqOe3, done3, sAddr3, sDqO3, rdata3);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;
  endtask

  task automatic test_write();
    int dc;
    runAccess(1'b0, 32'h10, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, dc);
    refMem[4] = merge(refMem[4], 32'hDEAD_BEEF, 4'h0);
    testCount++;
    if (dc !== 3 + WRP) begin
      failCount++;
      $display("[TB] FAIL write_done_cycle: got %0d, need %0d", dc, 3 + WRP);
    end
    testCount++;
    if (trAddr[1] !== 20'h4 || trDq[2] !== 32'hDEAD_BEEF || trBe[2] !== 4'h0) begin
      failCount++;
      $display("[TB] FAIL write_addr_data: addr=%h dq=%h be=%h, need 4 deadbeef 0",
               trAddr[1], trDq[2], trBe[2]);
    end
    for (int k = 0; k <= 4; k++) begin
      testCount++;
      if (trWe[k] !== (k != 2) || trDqOe[k] !== (k >= 1 && k <= 3) ||
          trBusy[k] !== (k <= 3) || trCe[k] !== !(k >= 1 && k <= 3)) begin
        failCount++;
        $display("[TB] FAIL write_trace c%0d: we=%b dqoe=%b busy=%b ce=%b, need %b %b %b %b",
                 k, trWe[k], trDqOe[k], trBusy[k], trCe[k],
                 k != 2, k >= 1 && k <= 3, k <= 3, !(k >= 1 && k <= 3));
      end
    end
  endtask

  task automatic test_read();
    int dc;
    runAccess(1'b1, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, dc);
    testCount++;
    if (dc !== 2 + RDW) begin
      failCount++;
      $display("[TB] FAIL read_done_cycle: got %0d, need %0d", dc, 2 + RDW);
    end
    for (int k = 0; k <= 3; k++) begin
      testCount++;
      if (trOe[k] !== !(k >= 1 && k <= 2) || trCe[k] !== !(k >= 1 && k <= 2)) begin
        failCount++;
        $display("[TB] FAIL read_trace c%0d: oe=%b ce=%b, need %b", k, trOe[k], trCe[k],
                 !(k >= 1 && k <= 2));
      end
    end
    testCount++;
    if (rdata !== 32'hDEAD_BEEF || rdata !== refMem[4]) begin
      failCount++;
      $display("[TB] FAIL read_data: got %h, need deadbeef", rdata);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    testCount++;
    if (rdata !== 32'hDEAD_BEEF) begin
      failCount++;
      $display("[TB] FAIL read_hold: got %h, need deadbeef", rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_write();
    int dc;
    runAccess(1'b0, 32'h10, 4'hE, 32'h0000_00A5, 1'b0, 1'b0, dc);
    refMem[4] = merge(refMem[4], 32'h0000_00A5, 4'hE);
    testCount++;
    if (trBe[1] !== 4'hE || trBe[2] !== 4'hE || trBe[3] !== 4'hE) begin
      failCount++;
      $display("[TB] FAIL byte_be: got %h %h %h, need e e e", trBe[1], trBe[2], trBe[3]);
    end
    runAccess(1'b1, 32'h10, 4'hF, 32'h0, 1'b0, 1'b0, dc);
    testCount++;
    if (rdata !== 32'hDEAD_BEA5 || rdata !== refMem[4]) begin
      failCount++;
      $display("[TB] FAIL byte_readback: got %h, need deadbea5", rdata);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    runAccess(1'b0, 32'h08, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1, dc);
    refMem[2] = merge(refMem[2], 32'hCAFE_F00D, 4'h0);
    testCount++;
    if (dc !== 3 + WRP || trBusy[dc > 0 ? dc : 0] !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_first: done cycle %0d, need %0d with busy 0", dc, 3 + WRP);
    end
    runAccess(1'b1, 32'h08, 4'hF, 32'h0, 1'b0, 1'b0, dc);
    testCount++;
    if (trCe[0] !== 1'b1 || trBusy[0] !== 1'b1 || trOe[0] !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_turnaround: ce=%b oe=%b busy=%b, need 1 1 1",
               trCe[0], trOe[0], trBusy[0]);
    end
    testCount++;
    if (dc !== 2 + RDW || rdata !== refMem[2]) begin
      failCount++;
      $display("[TB] FAIL b2b_second: done %0d rdata %h, need %0d %h", dc, rdata, 2 + RDW, refMem[2]);
    end
  endtask

  task automatic test_random();
    logic [3:0]  beTab [0:7];
    logic        r;
    logic [3:0]  idx;
    logic [9:0]  upper;
    logic [1:0]  low;
    logic [3:0]  b;
    logic [31:0] a, d;
    bit          drop;
    int          dc, expDc;
    beTab[0] = 4'h0; beTab[1] = 4'hC; beTab[2] = 4'h3; beTab[3] = 4'hE;
    beTab[4] = 4'hD; beTab[5] = 4'hB; beTab[6] = 4'h7; beTab[7] = 4'hF;
    for (int n = 0; n < 40; n++) begin
      r     = 1'($urandom_range(0, 1));
      idx   = 4'($urandom_range(0, 15));
      upper = 10'($urandom_range(0, 1023));
      low   = 2'($urandom_range(0, 3));
      b     = beTab[$urandom_range(0, 7)];
      d     = $urandom;
      drop  = ($urandom_range(0, 3) == 0);
      a     = {upper, 16'h0000, idx, low};
      expDc = r ? 2 + RDW : ((b == 4'hF) ? 1 : 3 + WRP);
      runAccess(r, a, b, d, drop, 1'b0, dc);
      testCount++;
      if (dc !== expDc) begin
        failCount++;
        $display("[TB] FAIL rand%0d_done: cycle %0d, need %0d (rw=%b be=%h)", n, dc, expDc, r, b);
      end
      if (expDc != 1) begin
        testCount++;
        if (trAddr[1] !== {16'h0000, idx}) begin
          failCount++;
          $display("[TB] FAIL rand%0d_addr: got %h, need %h", n, trAddr[1], {16'h0000, idx});
        end
      end
      if (r) begin
        testCount++;
        if (rdata !== refMem[idx]) begin
          failCount++;
          $display("[TB] FAIL rand%0d_rdata: got %h, need %h", n, rdata, refMem[idx]);
        end
      end else begin
        refMem[idx] = merge(refMem[idx], d, b);
      end
    end
  endtask

  task automatic test_null_write_and_rdwait();
    int dc;
    int dc3;
    pulseReset();
    runAccess(1'b0, 32'h14, 4'hF, 32'h5555_AAAA, 1'b0, 1'b0, dc);
    testCount++;
    if (dc !== 1 || trCe[0] !== 1'b1 || trCe[1] !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL null_write: done %0d ce %b%b, need 1 with ce 11", dc, trCe[0], trCe[1]);
    end
    dc3 = -1;
    rw = 1'b1; addr = 32'h10; wbe = 4'hF; wdata = 32'h0; req = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done3 === 1'b1) begin
        dc3 = k;
        break;
      end
      @(posedge clk); #1;
    end
    testCount++;
    if (dc3 !== 5 || rdata3 !== refMem[4] || busy3 !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL rdwait3_read: done %0d rdata %h busy %b, need 5 %h 0",
               dc3, rdata3, busy3, refMem[4]);
    end
    @(posedge clk); #1;
    req = 1'b0;
    pulseReset();
  endtask

  task automatic test_reset_mid_write();
    int dc;
    pulseReset();
    rw = 1'b0; addr = 32'h3C; wbe = 4'h0; wdata = 32'h0BAD_C0DE; req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    testCount++;
    if (sWe !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_pulse: we_n=%b in pulse cycle, need 0", sWe);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    testCount++;
    if (sWe !== 1'b1 || sDqOe !== 1'b0 || sCe !== 1'b1 || done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_pins: we=%b dqoe=%b ce=%b done=%b, need 1 0 1 0",
               sWe, sDqOe, sCe, done);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    testCount++;
    if (done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_nodone: done=%b, need 0", done);
    end
    @(posedge clk); #1;
    refMem[15] = merge(refMem[15], 32'h0BAD_C0DE, 4'h0);
    runAccess(1'b1, 32'h3C, 4'hF, 32'h0, 1'b0, 1'b0, dc);
    testCount++;
    if (dc !== 2 + RDW || rdata !== refMem[15]) begin
      failCount++;
      $display("[TB] FAIL midreset_readback: done %0d rdata %h, need %0d %h",
               dc, rdata, 2 + RDW, refMem[15]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) refMem[i] = initVal(i);
    test_reset();
    test_write();
    test_read();
    test_byte_write();
    test_back_to_back();
    test_random();
    test_null_write_and_rdwait();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
